regfile_multiport: RTL

// - Parametrised integer register file for the core datapath: 1 write port, 2 read ports.
// - Reads are registered, and a same-cycle write to a read address is forwarded to that read.
// - A clear sequencer walks the array after reset or on request, so the storage can map to RAM.
// - Sits between decode (read addresses) and writeback (write port).
//

---
 rtl/regfile_multiport_if.sv | 29 ++
 rtl/regfile_multiport.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport_if.sv
// Bus bundle for regfile_multiport: clear control, write port, dual read port.
// master drives requests (decode/writeback side); slave is the register file.
interface regfile_multiport_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              init_req;
   logic              busy;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic              rd_en;
   logic [ADDR_W-1:0] rd0_addr;
   logic [ADDR_W-1:0] rd1_addr;
   logic              rd_valid;
   logic [DATA_W-1:0] rd0_data;
   logic [DATA_W-1:0] rd1_data;
   logic [1:0]        parity_err;

   modport master (
      output init_req, we, waddr, wdata, rd_en, rd0_addr, rd1_addr,
      input  busy, rd_valid, rd0_data, rd1_data, parity_err
   );

   modport slave (
      input  init_req, we, waddr, wdata, rd_en, rd0_addr, rd1_addr,
      output busy, rd_valid, rd0_data, rd1_data, parity_err
   );
endinterface

// File: rtl/regfile_multiport.sv
// 1W/2R register file with registered, write-forwarding reads and a clear walk.
// Optional per-entry even parity is enabled by defining RF_PARITY_EN.
module regfile_multiport #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int DEPTH    = 32,
   parameter int ZERO_REG = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   regfile_multiport_if.slave   bus
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef RF_PARITY_EN
   localparam int ENTRY_W = DATA_W + 1;
`else
   localparam int ENTRY_W = DATA_W;
`endif

   typedef enum logic {CLEAR, IDLE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [ENTRY_W-1:0]  mem_q [DEPTH];

   logic                rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0]   rd0_q, rd0_d;
   logic [DATA_W-1:0]   rd1_q, rd1_d;

   logic                wr_ok;
   logic [ENTRY_W-1:0]  wr_entry;
   logic                ok0, ok1, byp0, byp1;
   logic [ENTRY_W-1:0]  ent0, ent1;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < (ADDR_W+1)'(DEPTH));
   endfunction

   function automatic logic is_zero_slot(input logic [ADDR_W-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
      return IDX_W'(a);
   endfunction

   function automatic logic [DATA_W-1:0] read_val(input logic addr_ok, input logic byp,
                                                  input logic [DATA_W-1:0] wd,
                                                  input logic [ENTRY_W-1:0] ent);
      if (!addr_ok) return '0;
      if (byp)      return wd;
      return ent[DATA_W-1:0];
   endfunction

   assign wr_ok = (state_q == IDLE) && bus.we && in_range(bus.waddr) && !is_zero_slot(bus.waddr);

`ifdef RF_PARITY_EN
   assign wr_entry = {^bus.wdata, bus.wdata};
`else
   assign wr_entry = bus.wdata;
`endif

   // A port reads storage only for a live, non-forced address; a matching accepted write wins.
   assign ok0  = in_range(bus.rd0_addr) && !is_zero_slot(bus.rd0_addr);
   assign ok1  = in_range(bus.rd1_addr) && !is_zero_slot(bus.rd1_addr);
   assign byp0 = wr_ok && (bus.waddr == bus.rd0_addr);
   assign byp1 = wr_ok && (bus.waddr == bus.rd1_addr);
   assign ent0 = mem_q[idx(bus.rd0_addr)];
   assign ent1 = mem_q[idx(bus.rd1_addr)];

   // Storage is left without reset so it can map onto RAM; the walk does the clearing.
   always_ff @(posedge clk) begin
      if (state_q == CLEAR) begin
         mem_q[idx(ptr_q)] <= '0;
      end else if (wr_ok) begin
         mem_q[idx(bus.waddr)] <= wr_entry;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= CLEAR;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         CLEAR: begin
            if (ptr_q == ADDR_W'(DEPTH - 1)) begin
               state_d = IDLE;
               ptr_d   = '0;
            end else begin
               ptr_d   = ptr_q + 1'b1;
            end
         end
         IDLE: begin
            if (bus.init_req) begin
               state_d = CLEAR;
               ptr_d   = '0;
            end
         end
         default: begin
            state_d = CLEAR;
            ptr_d   = '0;
         end
      endcase
   end

   always_comb begin
      rd_valid_d = 1'b0;
      rd0_d      = rd0_q;
      rd1_d      = rd1_q;
      if ((state_q == IDLE) && bus.rd_en) begin
         rd_valid_d = 1'b1;
         rd0_d      = read_val(ok0, byp0, bus.wdata, ent0);
         rd1_d      = read_val(ok1, byp1, bus.wdata, ent1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_valid_q <= 1'b0;
         rd0_q      <= '0;
         rd1_q      <= '0;
      end else begin
         rd_valid_q <= rd_valid_d;
         rd0_q      <= rd0_d;
         rd1_q      <= rd1_d;
      end
   end

`ifdef RF_PARITY_EN
   logic [1:0] perr_q, perr_d;

   // Only values actually fetched from storage can carry a parity fault.
   always_comb begin
      perr_d = perr_q;
      if ((state_q == IDLE) && bus.rd_en) begin
         perr_d[0] = ok0 && !byp0 && (^ent0);
         perr_d[1] = ok1 && !byp1 && (^ent1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) perr_q <= 2'b00;
      else      perr_q <= perr_d;
   end

   assign bus.parity_err = perr_q;
`else
   assign bus.parity_err = 2'b00;
`endif

   assign bus.busy     = (state_q == CLEAR);
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd0_data = rd0_q;
   assign bus.rd1_data = rd1_q;

endmodule
